// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_t;

    localparam int unsigned KEY_DEB_DEFAULT       = 500000;
    localparam int unsigned KEY_RPT_DELAY_DEFAULT = 25000000;
    localparam int unsigned KEY_RPT_RATE_DEFAULT  = 5000000;

    // Bits needed to hold a counter that runs from 0 up to maxval inclusive.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key: 2-FF synchronizer, debounce FSM, press pulse and level.
// Optional auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_bit
    import key_cond_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = KEY_DEB_DEFAULT,
    parameter int unsigned REPEAT_DELAY = KEY_RPT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_RATE  = KEY_RPT_RATE_DEFAULT,
    parameter bit          RPT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic nbin,
    output logic pulse,
    output logic level
);

    localparam int unsigned   DW     = cnt_width(DEB_CYCLES);
    localparam logic [DW-1:0] DC_ONE = DW'(1);
    localparam logic [DW-1:0] DC_MAX = DW'(DEB_CYCLES);

    logic [1:0]    sync;
    logic          p;
    key_state_t    state, state_n;
    logic [DW-1:0] dc, dc_n, dc_inc;
    logic          level_n;
    logic          accept;
    logic          rpt_pulse;

    assign p      = ~sync[1];
    assign dc_inc = dc + DC_ONE;

    // A first stable sample already satisfies DEB_CYCLES=1, so IDLE/HELD can jump straight across.
    always_comb begin
        state_n = state;
        dc_n    = dc;
        level_n = level;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (p) begin
                    if (DC_ONE == DC_MAX) begin
                        state_n = HELD;
                        dc_n    = '0;
                        level_n = 1'b1;
                        accept  = 1'b1;
                    end else begin
                        state_n = PRESS_WAIT;
                        dc_n    = DC_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_n = IDLE;
                    dc_n    = '0;
                end else if (dc_inc == DC_MAX) begin
                    state_n = HELD;
                    dc_n    = '0;
                    level_n = 1'b1;
                    accept  = 1'b1;
                end else begin
                    dc_n = dc_inc;
                end
            end
            HELD: begin
                if (!p) begin
                    if (DC_ONE == DC_MAX) begin
                        state_n = IDLE;
                        dc_n    = '0;
                        level_n = 1'b0;
                    end else begin
                        state_n = REL_WAIT;
                        dc_n    = DC_ONE;
                    end
                end
            end
            REL_WAIT: begin
                if (p) begin
                    state_n = HELD;
                    dc_n    = '0;
                end else if (dc_inc == DC_MAX) begin
                    state_n = IDLE;
                    dc_n    = '0;
                    level_n = 1'b0;
                end else begin
                    dc_n = dc_inc;
                end
            end
            default: begin
                state_n = IDLE;
                dc_n    = '0;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned   RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned   RW       = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RC_ONE   = RW'(1);
    localparam logic [RW-1:0] RC_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RC_RATE  = RW'(REPEAT_RATE);

    logic [RW-1:0] rc, rc_n, rc_inc, rc_target;
    logic          rpt_first, rpt_first_n;

    assign rc_inc    = rc + RC_ONE;
    assign rc_target = rpt_first ? RC_DELAY : RC_RATE;

    // Counting only while HELD persists means any entry to HELD restarts the initial delay.
    always_comb begin
        rc_n        = '0;
        rpt_first_n = 1'b1;
        rpt_pulse   = 1'b0;
        if (RPT_EN && state == HELD && state_n == HELD) begin
            if (rc_inc == rc_target) begin
                rpt_pulse   = 1'b1;
                rpt_first_n = 1'b0;
            end else begin
                rc_n        = rc_inc;
                rpt_first_n = rpt_first;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc        <= '0;
            rpt_first <= 1'b1;
        end else begin
            rc        <= rc_n;
            rpt_first <= rpt_first_n;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = RPT_EN ^ (REPEAT_DELAY == 0) ^ (REPEAT_RATE == 0);
    assign rpt_pulse  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '1;
            state <= IDLE;
            dc    <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[0], nbin};
            state <= state_n;
            dc    <= dc_n;
            pulse <= accept | rpt_pulse;
            level <= level_n;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: WIDTH independent debounced keys with press pulses and levels.
// Auto-repeat on REPEAT_MASK keys is compiled in with KEY_REPEAT_EN.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned      WIDTH        = 7,
    parameter int unsigned      DEB_CYCLES   = KEY_DEB_DEFAULT,
    parameter int unsigned      REPEAT_DELAY = KEY_RPT_DELAY_DEFAULT,
    parameter int unsigned      REPEAT_RATE  = KEY_RPT_RATE_DEFAULT,
    parameter logic [WIDTH-1:0] REPEAT_MASK  = WIDTH'(7'b1110000)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] nBIN,
    output logic [WIDTH-1:0] BOUT,
    output logic [WIDTH-1:0] LEVEL
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        key_debounce_bit #(
            .DEB_CYCLES  (DEB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .RPT_EN      (REPEAT_MASK[i])
        ) u_key (
            .clk  (CLK),
            .rst  (RST),
            .nbin (nBIN[i]),
            .pulse(BOUT[i]),
            .level(LEVEL[i])
        );
    end

endmodule
